// File: rtl/pad_attr_pkg.sv
// pad_attr_pkg: shared types and defaults for the pad attribute writer.
package pad_attr_pkg;
  localparam int AttrDwDef = 8;
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, DONE} state_e;
  typedef struct packed {
    logic       pull_en;
    logic       pull_sel;
    logic       open_drain;
    logic       schmitt;
    logic       keeper;
    logic       slew;
    logic [1:0] drive;
  } pad_attr_t;
endpackage

// File: rtl/pad_attr_writer_if.sv
// pad_attr_writer_if: request/response bundle between padctrl CSRs and the writer.
interface pad_attr_writer_if
  import pad_attr_pkg::*;
#(
  parameter int NumPads = 4,
  parameter int AttrDw  = AttrDwDef
);
  localparam int IdxW = NumPads > 1 ? $clog2(NumPads) : 1;
  logic                      req_i;
  logic                      ready_o;
  logic [IdxW-1:0]           pad_idx_i;
  logic [AttrDw-1:0]         attr_i;
  logic [AttrDw-1:0]         warl_mask_i;
  logic [NumPads*AttrDw-1:0] attr_o;
  logic [NumPads-1:0]        attr_upd_o;
  logic                      done_o;
  logic [AttrDw-1:0]         rdata_o;
  logic                      dropped_o;
  logic                      err_o;
  modport master (
    output req_i, pad_idx_i, attr_i, warl_mask_i,
    input  ready_o, attr_o, attr_upd_o, done_o, rdata_o, dropped_o, err_o
  );
  modport slave (
    input  req_i, pad_idx_i, attr_i, warl_mask_i,
    output ready_o, attr_o, attr_upd_o, done_o, rdata_o, dropped_o, err_o
  );
endinterface

// File: rtl/pad_attr_settle_cnt.sv
// pad_attr_settle_cnt: loadable down-counter that flags when it reaches zero.
module pad_attr_settle_cnt
  import pad_attr_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/pad_attr_writer.sv
// pad_attr_writer: masks attribute writes against the WARL mask, strobes the
// target pad field, waits a settle time, then pulses completion.
module pad_attr_writer
  import pad_attr_pkg::*;
#(
  parameter int                NumPads      = 4,
  parameter int                AttrDw       = AttrDwDef,
  parameter int                SettleCycles = 3,
  parameter logic [AttrDw-1:0] AttrRst      = '0
) (
  input logic              clk_i,
  input logic              rst_i,
  pad_attr_writer_if.slave bus
);
  localparam int IdxW = NumPads > 1 ? $clog2(NumPads) : 1;
  localparam int CntW = SettleCycles > 0 ? $clog2(SettleCycles + 1) : 1;
  localparam logic [IdxW:0] NumPadsW = (IdxW + 1)'(NumPads);
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles > 0 ? SettleCycles - 1 : 0);
  state_e                    state_q, state_d;
  logic [IdxW-1:0]           idx_q;
  logic [AttrDw-1:0]         rdata_q;
  logic                      dropped_q, err_q, cnt_zero, accept, idx_bad;
  logic [NumPads*AttrDw-1:0] attr_q;
  logic [NumPads-1:0]        upd;
  assign accept  = state_q == IDLE && bus.req_i;
  assign idx_bad = {1'b0, bus.pad_idx_i} >= NumPadsW;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.req_i ? (idx_bad ? DONE : APPLY) : IDLE;
      APPLY:   state_d = SettleCycles == 0 ? DONE : SETTLE;
      SETTLE:  state_d = cnt_zero ? DONE : SETTLE;
      default: state_d = IDLE;
    endcase
  end
  // rdata_q doubles as the write data for the APPLY cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      rdata_q   <= '0;
      dropped_q <= 1'b0;
      err_q     <= 1'b0;
      attr_q    <= {NumPads{AttrRst}};
    end else begin
      if (accept) begin
        idx_q     <= bus.pad_idx_i;
        rdata_q   <= bus.attr_i & bus.warl_mask_i;
        dropped_q <= |(bus.attr_i & ~bus.warl_mask_i);
        err_q     <= idx_bad;
      end
      for (int k = 0; k < NumPads; k++)
        if (upd[k]) attr_q[k*AttrDw +: AttrDw] <= rdata_q;
    end
  end
  for (genvar g = 0; g < NumPads; g++) begin : g_upd
    assign upd[g] = state_q == APPLY && idx_q == IdxW'(g);
  end
  pad_attr_settle_cnt #(.W(CntW)) u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (state_q == APPLY),
    .dec      (state_q == SETTLE),
    .load_val (CntLoad),
    .zero     (cnt_zero)
  );
  assign bus.ready_o    = state_q == IDLE;
  assign bus.done_o     = state_q == DONE;
  assign bus.attr_upd_o = upd;
  assign bus.attr_o     = attr_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.dropped_o  = dropped_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_pad_attr_writer.sv
// tb_pad_attr_writer: directed vector bench for pad_attr_writer, three configurations.
module tb_pad_attr_writer;
  import pad_attr_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;

  pad_attr_writer_if #(.NumPads(4)) b0 ();
  pad_attr_writer_if #(.NumPads(3)) b1 ();
  pad_attr_writer_if #(.NumPads(4)) b2 ();

  pad_attr_writer #(.NumPads(4), .SettleCycles(3)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  pad_attr_writer #(.NumPads(3), .SettleCycles(3)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  pad_attr_writer #(.NumPads(4), .SettleCycles(0)) u2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  typedef struct {
    int          pad;
    logic [7:0]  attr;
    logic [7:0]  mask;
    logic [7:0]  rdata;
    logic        drop;
    logic [31:0] attr_o;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic write_u0(input vec_t v);
    logic [3:0] exp_upd;
    exp_upd = 4'b0001 << v.pad;
    @(negedge clk);
    chk("ready_before", 32'(b0.ready_o), 32'd1);
    b0.req_i = 1'b1;
    b0.pad_idx_i = 2'(v.pad);
    b0.attr_i = v.attr;
    b0.warl_mask_i = v.mask;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) b0.req_i = 1'b0;
      chk("upd", 32'(b0.attr_upd_o), c == 1 ? 32'(exp_upd) : 32'd0);
      chk("ready_busy", 32'(b0.ready_o), 32'd0);
      chk("done", 32'(b0.done_o), c == 5 ? 32'd1 : 32'd0);
      if (c >= 2) chk("attr_o", b0.attr_o, v.attr_o);
    end
    chk("rdata", 32'(b0.rdata_o), 32'(v.rdata));
    chk("dropped", 32'(b0.dropped_o), 32'(v.drop));
    chk("err", 32'(b0.err_o), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2, 8'hA5, 8'hFF, 8'hA5, 1'b0, 32'h00A50000};
    vecs[1] = '{1, 8'hFF, 8'h0F, 8'h0F, 1'b1, 32'h00A50F00};
    vecs[2] = '{0, 8'h3C, 8'h3C, 8'h3C, 1'b0, 32'h00A50F3C};
    vecs[3] = '{3, 8'h5A, 8'hF0, 8'h50, 1'b1, 32'h50A50F3C};
    vecs[4] = '{2, 8'h00, 8'hFF, 8'h00, 1'b0, 32'h50000F3C};
    vecs[5] = '{1, 8'h0F, 8'h0F, 8'h0F, 1'b0, 32'h50000F3C};
    {b0.req_i, b1.req_i, b2.req_i} = '0;
    {b0.pad_idx_i, b1.pad_idx_i, b2.pad_idx_i} = '0;
    {b0.attr_i, b1.attr_i, b2.attr_i} = '0;
    {b0.warl_mask_i, b1.warl_mask_i, b2.warl_mask_i} = '0;
    repeat (3) @(negedge clk);
    chk("rst_attr", b0.attr_o, 32'd0);
    chk("rst_upd", 32'(b0.attr_upd_o), 32'd0);
    chk("rst_done", 32'(b0.done_o), 32'd0);
    chk("rst_rdata", 32'(b0.rdata_o), 32'd0);
    chk("rst_dropped", 32'(b0.dropped_o), 32'd0);
    chk("rst_err", 32'(b0.err_o), 32'd0);
    chk("rst_ready", 32'(b0.ready_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(b0.ready_o), 32'd1);
    chk("post_rst_attr", b0.attr_o, 32'd0);

    for (int i = 0; i < 6; i++) write_u0(vecs[i]);

    // back-to-back held request: pad 0 then pad 3
    @(negedge clk);
    b0.req_i = 1'b1; b0.pad_idx_i = 2'd0; b0.attr_i = 8'h11; b0.warl_mask_i = 8'hFF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin b0.pad_idx_i = 2'd3; b0.attr_i = 8'h22; end
      chk("hold_ready", 32'(b0.ready_o), c == 6 ? 32'd1 : 32'd0);
      chk("hold_upd", 32'(b0.attr_upd_o), c == 1 ? 32'd1 : 32'd0);
      chk("hold_done", 32'(b0.done_o), c == 5 ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    b0.req_i = 1'b0;
    chk("hold_upd2", 32'(b0.attr_upd_o), 32'h8);
    chk("hold_ready2", 32'(b0.ready_o), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk("hold_done2", 32'(b0.done_o), c == 5 ? 32'd1 : 32'd0);
    end
    chk("hold_attr", b0.attr_o, 32'h22000F11);
    chk("hold_rdata", 32'(b0.rdata_o), 32'h22);

    // NumPads=3: a valid write, then an out-of-range index
    @(negedge clk);
    b1.req_i = 1'b1; b1.pad_idx_i = 2'd1; b1.attr_i = 8'h77; b1.warl_mask_i = 8'hFF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) b1.req_i = 1'b0;
      chk("np3_done", 32'(b1.done_o), c == 5 ? 32'd1 : 32'd0);
    end
    chk("np3_attr", 32'(b1.attr_o), 32'h007700);
    @(negedge clk);
    b1.req_i = 1'b1; b1.pad_idx_i = 2'd3; b1.attr_i = 8'hFF; b1.warl_mask_i = 8'h0F;
    @(negedge clk);
    b1.req_i = 1'b0;
    chk("err_done", 32'(b1.done_o), 32'd1);
    chk("err_flag", 32'(b1.err_o), 32'd1);
    chk("err_upd", 32'(b1.attr_upd_o), 32'd0);
    chk("err_ready", 32'(b1.ready_o), 32'd0);
    chk("err_attr", 32'(b1.attr_o), 32'h007700);
    @(negedge clk);
    chk("err_ready_after", 32'(b1.ready_o), 32'd1);
    chk("err_upd_after", 32'(b1.attr_upd_o), 32'd0);
    chk("err_attr_after", 32'(b1.attr_o), 32'h007700);

    // SettleCycles=0
    @(negedge clk);
    b2.req_i = 1'b1; b2.pad_idx_i = 2'd3; b2.attr_i = 8'h81; b2.warl_mask_i = 8'hFF;
    @(negedge clk);
    b2.req_i = 1'b0;
    chk("s0_upd", 32'(b2.attr_upd_o), 32'h8);
    chk("s0_done_early", 32'(b2.done_o), 32'd0);
    @(negedge clk);
    chk("s0_done", 32'(b2.done_o), 32'd1);
    chk("s0_attr", b2.attr_o, 32'h81000000);
    chk("s0_rdata", 32'(b2.rdata_o), 32'h81);
    @(negedge clk);
    chk("s0_ready", 32'(b2.ready_o), 32'd1);

    // reset in the middle of a settle
    write_u0('{0, 8'h3C, 8'hFF, 8'h3C, 1'b0, 32'h22000F3C});
    @(negedge clk);
    b0.req_i = 1'b1; b0.pad_idx_i = 2'd1; b0.attr_i = 8'h44; b0.warl_mask_i = 8'hFF;
    @(negedge clk);
    b0.req_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_attr", b0.attr_o, 32'h2200443C);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_attr", b0.attr_o, 32'd0);
    chk("async_rst_ready", 32'(b0.ready_o), 32'd1);
    chk("async_rst_done", 32'(b0.done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abandon_done", 32'(b0.done_o), 32'd0);
      chk("abandon_ready", 32'(b0.ready_o), 32'd1);
      chk("abandon_attr", b0.attr_o, 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
